mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 57 +++++
 rtl/mult_div_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encoding, default latencies and small op-classification helpers used by
// both the unit itself and the pipeline decode/hazard logic.
package mdu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_MULT  = 4'h0;
  localparam logic [OP_W-1:0] OP_MULTU = 4'h1;
  localparam logic [OP_W-1:0] OP_DIV   = 4'h2;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'h3;
  localparam logic [OP_W-1:0] OP_MADD  = 4'h4;
  localparam logic [OP_W-1:0] OP_MADDU = 4'h5;
  localparam logic [OP_W-1:0] OP_MSUB  = 4'h6;
  localparam logic [OP_W-1:0] OP_MSUBU = 4'h7;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'h8;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'h9;

  localparam int DEF_MUL_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Ops that go through the multiplier (plain and accumulate forms)
  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Ops that occupy the unit for several cycles and raise busy
  function automatic logic is_multi_cycle(input logic [OP_W-1:0] op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

  // Ops whose operands are interpreted as two's complement
  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) ||
           (op == OP_MSUB);
  endfunction

  // Accumulate forms combine the product with the captured {hi,lo}
  function automatic logic is_madd_op(input logic [OP_W-1:0] op);
    return (op == OP_MADD) || (op == OP_MADDU);
  endfunction

  function automatic logic is_msub_op(input logic [OP_W-1:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit. Operands are captured when an op is accepted,
// the result is formed combinationally from those captured values, and a
// countdown FSM holds busy for a fixed latency before committing to HI/LO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int DW         = 2 * WIDTH;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W   = '0;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [OP_W-1:0]  cap_op;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [DW-1:0]    cap_acc;

  logic             sgn;
  logic [DW-1:0]    ext_a;
  logic [DW-1:0]    ext_b;
  logic [DW-1:0]    product;
  logic [DW-1:0]    mul_result;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] safe_b;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  logic [DW-1:0]    result;
  logic             accept;

  assign accept = (state == ST_IDLE) && start && !abort;

  // Multiplier: extend operands to double width so one unsigned multiply
  // yields the correct signed or unsigned 2*WIDTH-bit product, then fold in
  // the captured {hi,lo} for the accumulate forms.
  always_comb begin
    sgn     = is_signed_op(cap_op);
    ext_a   = {{WIDTH{sgn & cap_a[WIDTH-1]}}, cap_a};
    ext_b   = {{WIDTH{sgn & cap_b[WIDTH-1]}}, cap_b};
    product = ext_a * ext_b;
    if (is_madd_op(cap_op)) begin
      mul_result = cap_acc + product;
    end else if (is_msub_op(cap_op)) begin
      mul_result = cap_acc - product;
    end else begin
      mul_result = product;
    end
  end

  // Divider: divide magnitudes, then restore signs so the quotient truncates
  // toward zero and the remainder follows the dividend. The divisor is
  // forced non-zero so the datapath never produces X; the zero case is
  // replaced by its defined result below.
  always_comb begin
    a_neg     = sgn & cap_a[WIDTH-1];
    b_neg     = sgn & cap_b[WIDTH-1];
    mag_a     = a_neg ? (ZERO_W - cap_a) : cap_a;
    mag_b     = b_neg ? (ZERO_W - cap_b) : cap_b;
    safe_b    = (mag_b == ZERO_W) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    q_mag     = mag_a / safe_b;
    r_mag     = mag_a % safe_b;
    quotient  = (a_neg ^ b_neg) ? (ZERO_W - q_mag) : q_mag;
    remainder = a_neg ? (ZERO_W - r_mag) : r_mag;
  end

  // Final {hi,lo} selection, including the divide-by-zero and signed
  // overflow special cases
  always_comb begin
    result = mul_result;
    if (is_div_op(cap_op)) begin
      if (cap_b == ZERO_W) begin
        result = {cap_a, ALL_ONES};
      end else if (sgn && (cap_a == MOST_NEG) && (cap_b == ALL_ONES)) begin
        result = {ZERO_W, MOST_NEG};
      end else begin
        result = {remainder, quotient};
      end
    end
  end

  // Countdown FSM: accepts ops in IDLE, holds busy for the op's latency,
  // commits the result and pulses done on the last busy edge; abort drops
  // the op without touching HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cap_op  <= '0;
      cap_a   <= '0;
      cap_b   <= '0;
      cap_acc <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_multi_cycle(op)) begin
              cap_op  <= op;
              cap_a   <= a;
              cap_b   <= b;
              cap_acc <= {hi, lo};
              count   <= is_div_op(op) ? DIV_LOAD : MUL_LOAD;
              busy    <= 1'b1;
              state   <= ST_RUN;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            count <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (count <= CNT_ONE) begin
            hi    <= result[DW-1:WIDTH];
            lo    <= result[WIDTH-1:0];
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            count <= count - CNT_ONE;
          end
        end
        default: begin
          count <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
